// File: rtl/datapath_unit_pkg.sv
// Shared processor package: word width and ALU operation encodings used by
// the datapath and the controller.
package datapath_unit_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ALU_ZERO = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_PASS = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_AND  = 3'd6,
    ALU_INC  = 3'd7
  } alu_op_e;

  // Two's-complement overflow of a + b given the sign bits of a, b and the sum.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/datapath_unit_register_file.sv
// Two-read, one-write register file with asynchronous active-low clear.
// Reads are combinational and return the pre-write value during a write.
module register_file #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_clear_n,
  input  logic              i_w_wr,
  input  logic [AW-1:0]     i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_ra_rd,
  input  logic [AW-1:0]     i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic              i_rb_rd,
  input  logic [AW-1:0]     i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_w_wr) begin
      r_mem[i_w_addr] <= i_w_data;
    end
  end

  assign o_ra_data = i_ra_rd ? r_mem[i_ra_addr] : '0;
  assign o_rb_data = i_rb_rd ? r_mem[i_rb_addr] : '0;

endmodule

// File: rtl/datapath_unit.sv
// Processor datapath: register file, ALU with status flags, and a synchronous
// data memory whose contents survive clear.
module datapath_unit #(
  parameter int DATA_W   = datapath_unit_pkg::DATA_W,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256,
  localparam int RF_AW   = $clog2(RF_DEPTH),
  localparam int DM_AW   = $clog2(DM_DEPTH)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DM_AW-1:0]  d_addr,
  input  logic              d_wr,
  input  logic              rf_s,
  input  logic [RF_AW-1:0]  rf_w_addr,
  input  logic              rf_w_wr,
  input  logic [RF_AW-1:0]  rf_ra_addr,
  input  logic              rf_ra_rd,
  input  logic [RF_AW-1:0]  rf_rb_addr,
  input  logic              rf_rb_rd,
  input  logic [2:0]        alu_s0,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
);

  import datapath_unit_pkg::*;

  logic [DATA_W-1:0] r_dm [DM_DEPTH];
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_flag_z;
  logic              r_flag_c;
  logic              r_flag_v;

  alu_op_e           w_op;
  logic [DATA_W-1:0] w_b_op;
  logic              w_cin;
  logic              w_arith;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_alu;
  logic              w_carry;
  logic              w_ovf;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_flag_upd;

  register_file #(
    .DATA_W (DATA_W),
    .DEPTH  (RF_DEPTH)
  ) u_rf (
    .i_clk     (clock),
    .i_clear_n (clear),
    .i_w_wr    (rf_w_wr),
    .i_w_addr  (rf_w_addr),
    .i_w_data  (w_rf_wdata),
    .i_ra_rd   (rf_ra_rd),
    .i_ra_addr (rf_ra_addr),
    .o_ra_data (ra_data),
    .i_rb_rd   (rf_rb_rd),
    .i_rb_addr (rf_rb_addr),
    .o_rb_data (rb_data)
  );

  assign w_op = alu_op_e'(alu_s0);

  // ADD, SUB and INC share one adder: SUB is A + ~B + 1, INC is A + 0 + 1.
  always_comb begin
    w_b_op  = '0;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    case (w_op)
      ALU_ADD: begin
        w_b_op  = rb_data;
        w_arith = 1'b1;
      end
      ALU_SUB: begin
        w_b_op  = ~rb_data;
        w_cin   = 1'b1;
        w_arith = 1'b1;
      end
      ALU_INC: begin
        w_cin   = 1'b1;
        w_arith = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, ra_data} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_cin};

  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_ZERO: w_alu = '0;
      ALU_ADD,
      ALU_SUB,
      ALU_INC:  w_alu = w_sum[DATA_W-1:0];
      ALU_PASS: w_alu = ra_data;
      ALU_XOR:  w_alu = ra_data ^ rb_data;
      ALU_OR:   w_alu = ra_data | rb_data;
      ALU_AND:  w_alu = ra_data & rb_data;
      default:  w_alu = '0;
    endcase
  end

  assign w_carry = w_arith & w_sum[DATA_W];
  assign w_ovf   = w_arith & add_overflow(ra_data[DATA_W-1], w_b_op[DATA_W-1], w_sum[DATA_W-1]);

  assign alu_out    = w_alu;
  assign w_rf_wdata = rf_s ? r_mem_rdata : w_alu;
  assign w_flag_upd = rf_w_wr && !rf_s;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_flag_upd) begin
      r_flag_z <= (w_alu == '0);
      r_flag_c <= w_carry;
      r_flag_v <= w_ovf;
    end
  end

  // Memory array carries no reset so it maps to block RAM; clear only gates writes.
  always_ff @(posedge clock) begin
    if (d_wr && clear) begin
      r_dm[d_addr] <= ra_data;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_mem_rdata <= '0;
    end else begin
      r_mem_rdata <= r_dm[d_addr];
    end
  end

  assign mem_rdata = r_mem_rdata;
  assign flag_z    = r_flag_z;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed plus randomized bench for datapath_unit against an arithmetic
// reference model of the register file, ALU flags and data memory.
module tb_datapath_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_ra_addr;
  logic        rf_ra_rd;
  logic [3:0]  rf_rb_addr;
  logic        rf_rb_rd;
  logic [2:0]  alu_s0;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic [15:0] alu_out;
  logic [15:0] mem_rdata;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  datapath_unit dut (
    .clock      (clock),
    .clear      (clear),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_wr    (rf_w_wr),
    .rf_ra_addr (rf_ra_addr),
    .rf_ra_rd   (rf_ra_rd),
    .rf_rb_addr (rf_rb_addr),
    .rf_rb_rd   (rf_rb_rd),
    .alu_s0     (alu_s0),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .alu_out    (alu_out),
    .mem_rdata  (mem_rdata),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v)
  );

  always #5 clock = ~clock;

  logic [15:0] m_rf [16];
  logic [15:0] m_dm [256];
  logic [15:0] m_mrd;
  logic        m_z, m_c, m_v;
  bit          skip_mrd;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic on unsigned and signed views.
  function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, full, sfull;
    bit arith;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    full = 0; sfull = 0; arith = 1'b1; r = '0;
    case (op)
      3'd1: begin full = ua + ub;               sfull = sa + sb; end
      3'd2: begin full = ua + (65535 - ub) + 1; sfull = sa - sb; end
      3'd7: begin full = ua + 1;                sfull = sa + 1;  end
      3'd3: begin r = a;     arith = 1'b0; end
      3'd4: begin r = a ^ b; arith = 1'b0; end
      3'd5: begin r = a | b; arith = 1'b0; end
      3'd6: begin r = a & b; arith = 1'b0; end
      default: begin r = '0; arith = 1'b0; end
    endcase
    if (arith) begin
      r = full[15:0];
      c = full[16];
      v = (sfull > 32767) || (sfull < -32768);
    end else begin
      c = 1'b0;
      v = 1'b0;
    end
  endfunction

  // One clock with clear high: combinational checks mid-cycle, registered after the edge.
  task automatic tick(input string tag);
    logic [15:0] a, b, r, new_mrd;
    logic c, v;
    @(negedge clock);
    a = rf_ra_rd ? m_rf[rf_ra_addr] : 16'h0000;
    b = rf_rb_rd ? m_rf[rf_rb_addr] : 16'h0000;
    ref_alu(alu_s0, a, b, r, c, v);
    check({tag, ".ra_data"}, ra_data, a);
    check({tag, ".rb_data"}, rb_data, b);
    check({tag, ".alu_out"}, alu_out, r);
    new_mrd = m_dm[d_addr];
    if (rf_w_wr) begin
      m_rf[rf_w_addr] = rf_s ? m_mrd : r;
      if (!rf_s) begin
        m_z = (r == 16'h0000);
        m_c = c;
        m_v = v;
      end
    end
    if (d_wr) m_dm[d_addr] = a;
    m_mrd = new_mrd;
    @(posedge clock);
    #1;
    if (!skip_mrd) check({tag, ".mem_rdata"}, mem_rdata, m_mrd);
    check({tag, ".flag_z"}, {15'd0, flag_z}, {15'd0, m_z});
    check({tag, ".flag_c"}, {15'd0, flag_c}, {15'd0, m_c});
    check({tag, ".flag_v"}, {15'd0, flag_v}, {15'd0, m_v});
    if (tag != "" && tag != "rnd")
      $display("%0t %s op=%0d ra=%h rb=%h alu=%h mrd=%h zcv=%b%b%b",
               $time, tag, alu_s0, a, b, r, mem_rdata, flag_z, flag_c, flag_v);
  endtask

  // Build a register value from zero by doubling and incrementing.
  task automatic set_reg(input logic [3:0] idx, input logic [15:0] val);
    d_wr = 1'b0; rf_s = 1'b0; rf_w_wr = 1'b1; rf_w_addr = idx;
    rf_ra_rd = 1'b0; rf_rb_rd = 1'b0; alu_s0 = 3'd0;
    tick("");
    for (int i = 15; i >= 0; i--) begin
      rf_ra_addr = idx; rf_rb_addr = idx; rf_ra_rd = 1'b1; rf_rb_rd = 1'b1; alu_s0 = 3'd1;
      tick("");
      if (val[i]) begin
        rf_rb_rd = 1'b0; alu_s0 = 3'd7;
        tick("");
      end
    end
    rf_w_wr = 1'b0;
  endtask

  initial begin
    logic        sz, sc, sv;
    logic [7:0]  keep_addr;
    logic [15:0] keep_word;

    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    for (int i = 0; i < 256; i++) m_dm[i] = '0;
    m_mrd = '0; m_z = 0; m_c = 0; m_v = 0; skip_mrd = 1'b0;
    clear = 1'b0; d_addr = '0; d_wr = 0; rf_s = 0; rf_w_addr = '0; rf_w_wr = 0;
    rf_ra_addr = '0; rf_ra_rd = 0; rf_rb_addr = '0; rf_rb_rd = 0; alu_s0 = '0;

    #1;
    check("por.mem_rdata", mem_rdata, 16'h0000);
    check("por.flag_z", {15'd0, flag_z}, 16'h0000);
    @(posedge clock); #1;
    clear = 1'b1;

    // Fill data memory with zeros so every later read has a known value.
    skip_mrd = 1'b1;
    d_wr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d_addr = 8'(i);
      tick("");
    end
    d_wr = 1'b0; d_addr = 8'h00;
    tick("");
    skip_mrd = 1'b0;

    // Load path through data memory.
    set_reg(4'd8, 16'h00F0);
    d_wr = 1'b1; d_addr = 8'h1A; rf_ra_addr = 4'd8; rf_ra_rd = 1'b1;
    tick("store_1a");
    d_wr = 1'b0;
    tick("read_1a");
    rf_s = 1'b1; rf_w_addr = 4'd3; rf_w_wr = 1'b1;
    tick("load_r3");
    rf_s = 1'b0; rf_w_wr = 1'b0; rf_ra_addr = 4'd3; rf_ra_rd = 1'b1;
    #1 check("load.r3", ra_data, 16'h00F0);

    // Signed overflow on ADD.
    set_reg(4'd1, 16'h7FFF);
    set_reg(4'd2, 16'h0001);
    rf_ra_addr = 4'd1; rf_rb_addr = 4'd2; rf_ra_rd = 1; rf_rb_rd = 1;
    alu_s0 = 3'd1; rf_s = 0; rf_w_addr = 4'd4; rf_w_wr = 1;
    tick("add_ovf");
    check("add_ovf.v", {15'd0, flag_v}, 16'h0001);
    check("add_ovf.c", {15'd0, flag_c}, 16'h0000);
    check("add_ovf.z", {15'd0, flag_z}, 16'h0000);
    rf_w_wr = 0; rf_ra_addr = 4'd4;
    #1 check("add_ovf.r4", ra_data, 16'h8000);

    // SUB of equal operands gives zero with no borrow.
    set_reg(4'd5, 16'h1234);
    set_reg(4'd6, 16'h1234);
    rf_ra_addr = 4'd5; rf_rb_addr = 4'd6; rf_ra_rd = 1; rf_rb_rd = 1;
    alu_s0 = 3'd2; rf_s = 0; rf_w_addr = 4'd7; rf_w_wr = 1;
    tick("sub_zero");
    check("sub_zero.z", {15'd0, flag_z}, 16'h0001);
    check("sub_zero.c", {15'd0, flag_c}, 16'h0001);
    check("sub_zero.v", {15'd0, flag_v}, 16'h0000);
    rf_w_wr = 0; rf_ra_addr = 4'd7;
    #1 check("sub_zero.r7", ra_data, 16'h0000);

    // Store while reading the same memory word returns the old word first.
    d_wr = 1; d_addr = 8'h80; rf_ra_addr = 4'd3; rf_ra_rd = 1;
    tick("store_80_old");
    rf_ra_addr = 4'd4;
    tick("store_80_rdw");
    check("rdw.old", mem_rdata, 16'h00F0);
    d_wr = 0;
    tick("read_80");
    check("rdw.new", mem_rdata, 16'h8000);

    // Disabled read ports feed zeros; flags hold without a write.
    sz = flag_z; sc = flag_c; sv = flag_v;
    rf_ra_rd = 0; rf_rb_rd = 0; alu_s0 = 3'd1; rf_w_wr = 0;
    #1;
    check("dis.ra", ra_data, 16'h0000);
    check("dis.rb", rb_data, 16'h0000);
    check("dis.alu", alu_out, 16'h0000);
    tick("disabled");
    check("dis.hold", {13'd0, flag_z, flag_c, flag_v}, {13'd0, sz, sc, sv});

    for (int k = 0; k < 300; k++) begin
      d_addr = 8'($urandom); d_wr = 1'($urandom); rf_s = 1'($urandom);
      rf_w_addr = 4'($urandom); rf_w_wr = 1'($urandom);
      rf_ra_addr = 4'($urandom); rf_ra_rd = ($urandom_range(0, 3) != 0);
      rf_rb_addr = 4'($urandom); rf_rb_rd = ($urandom_range(0, 3) != 0);
      alu_s0 = 3'($urandom);
      tick("rnd");
    end

    // Mid-cycle reset: everything observable clears without a clock edge.
    keep_addr = 8'h00;
    for (int i = 0; i < 256; i++) if (m_dm[i] != 16'h0000) keep_addr = 8'(i);
    keep_word = m_dm[keep_addr];
    d_wr = 0; rf_w_wr = 0;
    #2 clear = 1'b0;
    #1;
    check("rst.mem_rdata", mem_rdata, 16'h0000);
    check("rst.flags", {13'd0, flag_z, flag_c, flag_v}, 16'h0000);
    rf_ra_rd = 1; rf_rb_rd = 1;
    for (int i = 0; i < 16; i++) begin
      rf_ra_addr = 4'(i); rf_rb_addr = 4'(15 - i);
      #1;
      check("rst.ra", ra_data, 16'h0000);
      check("rst.rb", rb_data, 16'h0000);
    end
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_mrd = '0; m_z = 0; m_c = 0; m_v = 0;

    // Writes presented while clear is low are dropped.
    rf_ra_addr = 4'd9; rf_w_addr = 4'd9; rf_w_wr = 1; rf_s = 0; alu_s0 = 3'd7;
    d_wr = 1; d_addr = keep_addr;
    @(posedge clock); #1;
    check("rst_edge.mem_rdata", mem_rdata, 16'h0000);
    check("rst_edge.r9", ra_data, 16'h0000);
    check("rst_edge.flag_z", {15'd0, flag_z}, 16'h0000);
    clear = 1'b1;
    rf_w_wr = 0; d_wr = 0;
    tick("post_reset");
    check("persist.dm", mem_rdata, keep_word);

    for (int k = 0; k < 200; k++) begin
      d_addr = 8'($urandom); d_wr = 1'($urandom); rf_s = 1'($urandom);
      rf_w_addr = 4'($urandom); rf_w_wr = 1'($urandom);
      rf_ra_addr = 4'($urandom); rf_ra_rd = ($urandom_range(0, 3) != 0);
      rf_rb_addr = 4'($urandom); rf_rb_rd = ($urandom_range(0, 3) != 0);
      alu_s0 = 3'($urandom);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
